display_scan_driver: RTL and testbench
======================================

// Module: display_scan_driver
// PURPOSE
//  Time-multiplexed driver for the 4-digit countdown display of the traffic light controller.
//  Takes two binary countdown values (0..99), such as the remaining green/red time for two lanes.
//  Converts each value to BCD with a sequential subtractor.
//  Scans the four digits, presenting one 4-bit digit code per scan slot to the downstream
//  7-segment decoder (code 10 = blank). Drives active-low anode enables in step with the code.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles per digit slot; legal range >= 2
//  LZ_BLANK     1      1: a tens digit of 0 is shown blank (code 10); 0: shown as 0
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  synchronous reset, active-high
//  val_a       in   7  binary value for left pair (digits 0,1); >99 saturates to 99
//  val_b       in   7  binary value for right pair (digits 2,3); >99 saturates to 99
//  load        in   1  single-cycle request to capture val_a/val_b; sampled only when busy=0
//  busy        out  1  high from accepted load until new digits are committed to display
//  digit_code  out  4  digit for current slot -> segment decoder input; 0..9 or 10 (blank)
//  an          out  4  active-low anode enables; exactly one bit low at all times
// BEHAVIOUR
//  Reset: busy=0, digit_code=10, an=4'b1110, prescaler=0, slot idx=0,
//   display regs all blank (code 10), FSM=IDLE.
//  Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick=1 in the cycle it equals REFRESH_DIV-1.
//  Slot idx (2b): advances on tick, 3 wraps to 0. frame_end = tick && idx==3.
//  Slot map: idx0 = a tens (an=1110), idx1 = a units (an=1101),
//   idx2 = b tens (an=1011), idx3 = b units (an=0111).
//  digit_code/an are registered. Both update together in the cycle after tick,
//   so each slot lasts exactly REFRESH_DIV cycles.
//  Conversion FSM states: IDLE -> CONV -> PEND -> IDLE.
//   IDLE: load=1 captures min(val,99) for both inputs, clears tens counters,
//    sets busy=1, and moves to CONV.
//   CONV: each cycle, each channel whose remainder is >=10 subtracts 10 and increments its tens.
//    Both channels run in parallel. Move to PEND in the cycle after both remainders are <10.
//    CONV lasts at most 10 cycles.
//   PEND: wait for frame_end. On that cycle, commit tens/units to the display regs,
//    clear busy, and return to IDLE.
//  The new frame starts on idx0 with committed data. Frames never mix old and new values.
//  If CONV completes in the same cycle as frame_end, the commit waits for the next frame_end.
//  load while busy=1 is ignored; no queueing. load in the commit cycle is also ignored.
//  Leading-zero blanking (LZ_BLANK=1): tens=0 gives code 10. Units are always shown, including 0.
//  Before the first commit, all slots output code 10.
//  Reset mid-operation (any state) aborts conversion immediately and returns to the reset values.
//  Widths: remainder and tens are 7b and 4b internally. After saturation, tens never exceeds 9.
// TESTING (REFRESH_DIV=4 unless stated)
//  1 rst 3 cycles, then release -> an=1110, digit_code=10, busy=0;
//    over 16 cycles an steps 1110,1101,1011,0111 every 4 cycles, all codes 10.
//  2 load 1 cycle with val_a=37, val_b=5 -> busy=1 until frame_end;
//    next frame codes 3,7,10,5 with an 1110,1101,1011,0111.
//  3 val_a=0, val_b=100 -> codes 10,0,9,9 (blanking plus saturation); busy drops at frame_end.
//  4 load 37/5, then load 12/34 two cycles later while busy -> second load ignored;
//    display shows 3,7,10,5; a later load of 12/34 with busy=0 gives 1,2,3,4.
//  5 rst asserted 3 cycles after load (mid-CONV) -> next cycle busy=0, all codes 10, an=1110;
//    a fresh load of 99/99 gives 9,9,9,9.
//  6 LZ_BLANK=0, val_a=7, val_b=0 -> codes 0,7,0,0.

Source files
------------

// File: rtl/display_scan_driver.sv
// Four-digit multiplexed countdown display driver: two binary values (0..99) are
// converted to BCD by repeated subtraction and committed only on frame boundaries.
module display_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] val_a,
  input  logic [6:0] val_b,
  input  logic       load,
  output logic       busy,
  output logic [3:0] digit_code,
  output logic [3:0] an
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] BLANK = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_PEND
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_n;
  logic          tick;
  logic          frame_end;

  logic [6:0] rem_a, rem_b;
  logic [3:0] tens_a, tens_b;
  logic [3:0] disp   [4];
  logic [3:0] disp_n [4];

  logic capture, step, commit;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [3:0] tens_code(input logic [3:0] t);
    return (LZ_BLANK && (t == 4'd0)) ? BLANK : t;
  endfunction

  assign tick      = (cnt == LAST);
  assign frame_end = tick && (idx == 2'd3);
  assign idx_n     = idx + 2'd1;

  // Conversion control FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_n = S_CONV;
        end
      end
      S_CONV: begin
        if ((rem_a < 7'd10) && (rem_b < 7'd10)) state_n = S_PEND;
        else                                     step    = 1'b1;
      end
      S_PEND: begin
        if (frame_end) begin
          commit  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Next display contents; the output register reads this so the committing
  // tick already presents the new tens digit in slot 0.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) disp_n[i] = disp[i];
    if (commit) begin
      disp_n[0] = tens_code(tens_a);
      disp_n[1] = rem_a[3:0];
      disp_n[2] = tens_code(tens_b);
      disp_n[3] = rem_b[3:0];
    end
  end

  // Subtract-by-ten BCD datapath and display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_a  <= '0;
      rem_b  <= '0;
      tens_a <= '0;
      tens_b <= '0;
      busy   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) disp[i] <= BLANK;
    end else begin
      if (capture) begin
        rem_a  <= sat99(val_a);
        rem_b  <= sat99(val_b);
        tens_a <= '0;
        tens_b <= '0;
        busy   <= 1'b1;
      end
      if (step) begin
        if (rem_a >= 7'd10) begin
          rem_a  <= rem_a - 7'd10;
          tens_a <= tens_a + 4'd1;
        end
        if (rem_b >= 7'd10) begin
          rem_b  <= rem_b - 7'd10;
          tens_b <= tens_b + 4'd1;
        end
      end
      if (commit) busy <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) disp[i] <= disp_n[i];
    end
  end

  // Scan timing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      digit_code <= BLANK;
      an         <= 4'b1110;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx        <= idx_n;
        an         <= ~(4'b0001 << idx_n);
        digit_code <= disp_n[idx_n];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: expected digit codes are queued at
// each accepted load and compared against the frame that follows busy falling.
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] val_a, val_b;
  logic       load;
  logic       busy, busy0;
  logic [3:0] digit_code, digit_code0;
  logic [3:0] an, an0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] lz1;
    logic [15:0] lz0;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  display_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .val_a(val_a), .val_b(val_b), .load(load),
    .busy(busy), .digit_code(digit_code), .an(an)
  );

  display_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .val_a(val_a), .val_b(val_b), .load(load),
    .busy(busy0), .digit_code(digit_code0), .an(an0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int s);
    case (s)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [15:0] codes(input int a, input int b, input bit lz);
    int sa, sb_;
    logic [3:0] ta, ua, tb_, ub;
    sa  = (a > 99) ? 99 : a;
    sb_ = (b > 99) ? 99 : b;
    ta  = 4'(sa / 10);
    ua  = 4'(sa % 10);
    tb_ = 4'(sb_ / 10);
    ub  = 4'(sb_ % 10);
    if (lz && ta == 4'd0)  ta  = 4'd10;
    if (lz && tb_ == 4'd0) tb_ = 4'd10;
    return {ta, ua, tb_, ub};
  endfunction

  task automatic reset_sweep(input string tag);
    @(negedge clk) rst = 1'b1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check({tag, "_busy"}, busy, 0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check({tag, "_an"}, an, an_of(k / 4));
      check({tag, "_code"}, digit_code, 10);
      check({tag, "_code_nolz"}, digit_code0, 10);
    end
  endtask

  task automatic drive_load(input int a, input int b, input bit accept);
    @(negedge clk);
    val_a = 7'(a);
    val_b = 7'(b);
    load  = 1'b1;
    if (accept) sb.push_back('{lz1: codes(a, b, 1'b1), lz0: codes(a, b, 1'b0)});
    @(negedge clk) load = 1'b0;
    if (accept) check("busy_rise", busy, 1);
  endtask

  task automatic expect_frame(input string tag);
    exp_t       e;
    logic [3:0] prev;
    int         n;
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e    = sb.pop_front();
    prev = an;
    n    = 0;
    while (busy === 1'b1 && n < 400) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_frame_boundary"}, prev, 4'b0111);
    for (int s = 0; s < 4; s++) begin
      logic [15:0] w1, w0;
      if (s > 0) repeat (4) @(negedge clk);
      w1 = e.lz1 >> (4 * (3 - s));
      w0 = e.lz0 >> (4 * (3 - s));
      check($sformatf("%s_an%0d", tag, s), an, an_of(s));
      check($sformatf("%s_code%0d", tag, s), digit_code, w1[3:0]);
      check($sformatf("%s_nolz_code%0d", tag, s), digit_code0, w0[3:0]);
    end
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    val_a = '0;
    val_b = '0;

    reset_sweep("reset");

    drive_load(37, 5, 1'b1);
    expect_frame("load_37_5");

    drive_load(0, 100, 1'b1);
    expect_frame("blank_sat");

    drive_load(37, 5, 1'b1);
    @(negedge clk);
    drive_load(12, 34, 1'b0);
    expect_frame("busy_ignore");
    drive_load(12, 34, 1'b1);
    expect_frame("load_12_34");

    drive_load(50, 60, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_code", digit_code, 10);
    check("midrst_an", an, 4'b1110);
    reset_sweep("post_rst");
    drive_load(99, 99, 1'b1);
    expect_frame("load_99_99");

    drive_load(7, 0, 1'b1);
    expect_frame("lz_7_0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
